multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the 32-bit MIPS multicycle datapath.
// Sequences fetch, decode, memory, ALU, branch and jump steps. All outputs are combinational.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   state_t     state, state_next;
   logic       pcwrite, branch;
   logic       irwrite_d, regwrite_d, memwrite_d, illegal_d;
   logic [2:0] funct_alu;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      case (funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_alu = 3'b010;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite_d  = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      illegal_d  = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      case (state)
         FETCH: begin
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            irwrite_d  = mem_ready;
            pcwrite    = mem_ready;
            state_next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = ALU_ADD;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = EXECUTE;
               OP_BEQ:       state_next = BRANCH;
               OP_ADDI:      state_next = ADDIEXEC;
               OP_J:         state_next = JUMP;
               default: begin
                  state_next = FETCH;
                  illegal_d  = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
            state_next = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord       = 1'b1;
            state_next = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_d = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_d = 1'b1;
            state_next = mem_ready ? FETCH : MEMWR;
         end
         EXECUTE: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            state_next = ALUWB;
         end
         ALUWB: begin
            regdst     = 1'b1;
            regwrite_d = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
         ADDIEXEC: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = ALU_ADD;
            state_next = ADDIWB;
         end
         ADDIWB: regwrite_d = 1'b1;
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // Reset forces FETCH asynchronously, so mask the write enables FETCH would otherwise raise.
   assign irwrite  = irwrite_d  & ~reset;
   assign regwrite = regwrite_d & ~reset;
   assign memwrite = memwrite_d & ~reset;
   assign illegal  = illegal_d  & ~reset;
   assign pcen     = (pcwrite | (branch & zero)) & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output comparison against an
// instruction-step model, with directed scenarios and randomized back-to-back instructions.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   int n_cmp = 0;
   int n_err = 0;
   int obs_memwrite, obs_regwrite, obs_wb_mem;

   typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
                 S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP} step_t;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
      if (f == 6'd32) return 3'd2;
      if (f == 6'd34) return 3'd6;
      if (f == 6'd36) return 3'd0;
      if (f == 6'd37) return 3'd1;
      if (f == 6'd42) return 3'd7;
      return 3'd2;
   endfunction

   function automatic bit is_legal(input logic [5:0] o);
      return o inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
   endfunction

   // Expected output vector {pcen,irwrite,regwrite,memwrite,iord,memtoreg,regdst,alusrca,
   // alusrcb,pcsrc,alucontrol,illegal} for one step of an instruction.
   function automatic logic [15:0] model(input step_t s, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic mr);
      logic pe = 0, irw = 0, rw = 0, mw = 0, io = 0, m2r = 0, rd = 0, sa = 0, ill = 0;
      logic [1:0] sb = 0, ps = 0;
      logic [2:0] ac = 0;
      case (s)
         S_FETCH:    begin sb = 1; ac = 2; irw = mr; pe = mr; end
         S_DECODE:   begin sb = 3; ac = 2; ill = !is_legal(o); end
         S_MEMADR:   begin sa = 1; sb = 2; ac = 2; end
         S_MEMRD:    io = 1;
         S_MEMWB:    begin m2r = 1; rw = 1; end
         S_MEMWR:    begin io = 1; mw = 1; end
         S_EXEC:     begin sa = 1; ac = alu_of_funct(f); end
         S_ALUWB:    begin rd = 1; rw = 1; end
         S_BRANCH:   begin sa = 1; ac = 6; ps = 1; pe = z; end
         S_ADDIEXEC: begin sa = 1; sb = 2; ac = 2; end
         S_ADDIWB:   rw = 1;
         S_JUMP:     begin ps = 2; pe = 1; end
         default:    ;
      endcase
      return {pe, irw, rw, mw, io, m2r, rd, sa, sb, ps, ac, ill};
   endfunction

   // Called at posedge+1: apply inputs, compare mid-cycle, advance one edge.
   task automatic step(input step_t s, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr);
      logic [15:0] exp_v, obs_v;
      op = o; funct = f; zero = z; mem_ready = mr;
      #2;
      exp_v = model(s, o, f, z, mr);
      obs_v = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, alucontrol, illegal};
      n_cmp++;
      if (obs_v !== exp_v) begin
         n_err++;
         $display("FAIL step_%s op=%b funct=%b z=%b mr=%b: got %h expected %h",
                  s.name(), o, f, z, mr, obs_v, exp_v);
      end
      if (memwrite === 1'b1) obs_memwrite++;
      if (regwrite === 1'b1) obs_regwrite++;
      if (regwrite === 1'b1 && memtoreg === 1'b1) obs_wb_mem++;
      @(posedge clk);
      #1;
   endtask

   task automatic exec_instr(input logic [5:0] o, input logic [5:0] f, input logic zb,
                             input int sf, input int sm);
      for (int i = 0; i < sf; i++) step(S_FETCH, o, f, 1'($urandom), 1'b0);
      step(S_FETCH, o, f, 1'($urandom), 1'b1);
      step(S_DECODE, o, f, 1'($urandom), 1'($urandom));
      case (o)
         6'd35: begin
            step(S_MEMADR, o, f, 1'($urandom), 1'($urandom));
            for (int i = 0; i < sm; i++) step(S_MEMRD, o, f, 1'($urandom), 1'b0);
            step(S_MEMRD, o, f, 1'($urandom), 1'b1);
            step(S_MEMWB, o, f, 1'($urandom), 1'($urandom));
         end
         6'd43: begin
            step(S_MEMADR, o, f, 1'($urandom), 1'($urandom));
            for (int i = 0; i < sm; i++) step(S_MEMWR, o, f, 1'($urandom), 1'b0);
            step(S_MEMWR, o, f, 1'($urandom), 1'b1);
         end
         6'd0: begin
            step(S_EXEC, o, f, 1'($urandom), 1'($urandom));
            step(S_ALUWB, o, f, 1'($urandom), 1'($urandom));
         end
         6'd4:  step(S_BRANCH, o, f, zb, 1'($urandom));
         6'd8: begin
            step(S_ADDIEXEC, o, f, 1'($urandom), 1'($urandom));
            step(S_ADDIWB, o, f, 1'($urandom), 1'($urandom));
         end
         6'd2:  step(S_JUMP, o, f, 1'($urandom), 1'($urandom));
         default: ;
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 6'd35; funct = 0; zero = 1'b1; mem_ready = 1'b1;
      #2;
      n_cmp++;
      if ({pcen, irwrite, regwrite, memwrite, illegal} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_enables: got %b expected 00000", {pcen, irwrite, regwrite, memwrite, illegal});
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_lw();
      obs_regwrite = 0; obs_wb_mem = 0;
      exec_instr(6'd35, 6'd0, 1'b0, 0, 0);
      n_cmp++;
      if (obs_regwrite !== 1 || obs_wb_mem !== 1) begin
         n_err++;
         $display("FAIL lw_writeback: regwrite cycles %0d, with memtoreg %0d, expected 1 and 1",
                  obs_regwrite, obs_wb_mem);
      end
   endtask

   task automatic test_sw_stall();
      obs_memwrite = 0;
      exec_instr(6'd43, 6'd0, 1'b0, 1, 3);
      n_cmp++;
      if (obs_memwrite !== 4) begin
         n_err++;
         $display("FAIL sw_memwrite_cycles: got %0d expected 4", obs_memwrite);
      end
   endtask

   task automatic test_rtype();
      exec_instr(6'd0, 6'b101010, 1'b0, 0, 0);
      exec_instr(6'd0, 6'b100100, 1'b0, 0, 0);
      exec_instr(6'd0, 6'b111111, 1'b0, 0, 0);
   endtask

   task automatic test_beq();
      exec_instr(6'd4, 6'd0, 1'b1, 0, 0);
      exec_instr(6'd4, 6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_illegal();
      obs_memwrite = 0; obs_regwrite = 0;
      exec_instr(6'b111111, 6'd0, 1'b0, 0, 0);
      exec_instr(6'd2, 6'd0, 1'b0, 0, 0);
      n_cmp++;
      if (obs_memwrite !== 0 || obs_regwrite !== 0) begin
         n_err++;
         $display("FAIL illegal_no_writes: memwrite %0d regwrite %0d, expected 0 and 0",
                  obs_memwrite, obs_regwrite);
      end
   endtask

   task automatic test_reset_in_memwr();
      step(S_FETCH, 6'd43, 6'd0, 1'b0, 1'b1);
      step(S_DECODE, 6'd43, 6'd0, 1'b0, 1'b1);
      step(S_MEMADR, 6'd43, 6'd0, 1'b0, 1'b1);
      step(S_MEMWR, 6'd43, 6'd0, 1'b0, 1'b0);
      mem_ready = 1'b0;
      #2;
      n_cmp++;
      if (memwrite !== 1'b1) begin
         n_err++;
         $display("FAIL memwr_wait_before_reset: memwrite %b expected 1", memwrite);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (memwrite !== 1'b0) begin
         n_err++;
         $display("FAIL memwr_async_reset: memwrite %b expected 0", memwrite);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exec_instr(6'd8, 6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] legal_ops [6] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43};
      logic [5:0] functs [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
      logic [5:0] o, f;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do o = 6'($urandom); while (is_legal(o));
         end else begin
            o = legal_ops[$urandom_range(0, 5)];
         end
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
         exec_instr(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_rtype();
      test_beq();
      test_illegal();
      test_reset_in_memwr();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
